sb_arbiter: RTL and testbench
=============================

Name: sb_arbiter

Overview:
- Round-robin arbiter and transaction sequencer for the SB bus.
- Shares one SB master port among NUM_MASTERS requesters.
- Drives the granted master's transfer size to the SB address decoder, then waits for the decoder's address check.
- Counts data beats against slave ready, and releases the bus on completion or on a decoder address error.

Parameters:
- NUM_MASTERS, 3, number of requesting masters (2..8).
- SB_TRANS_SIZE, 3, width of the size field.
- ID_WIDTH, 3, width of sb_master_id (must be ≥ clog2(NUM_MASTERS)).
- TIMEOUT_CYCLES, 255, maximum cycles without sb_ready in DATA; used only when SB_ARB_TIMEOUT_EN is defined.

Ports:
- sb_clk, input, 1, bus clock.
- sb_resetn, input, 1, synchronous active-low reset.
- m_req, input, NUM_MASTERS, per-master request; must be held until the grant drops.
- m_size, input, NUM_MASTERS*SB_TRANS_SIZE, packed per-master sizes; master i occupies bits [i*3+:3].
- sb_ready, input, 1, slave beat-accept strobe.
- add_notokay, input, 1, registered address-error flag from the SB decoder.
- m_grant, output, NUM_MASTERS, one-hot grant.
- sb_size, output, SB_TRANS_SIZE, latched size of the granted master, sent to the decoder.
- sb_master_id, output, ID_WIDTH, index of the granted master.
- sb_busy, output, 1, high in every state except IDLE.
- sb_last, output, 1, high during DATA while beats_left == 1.
- arb_err, output, 1, one-cycle pulse on an aborted transaction.

Behaviour:
- One clock. Reset is synchronous and active-low (sb_resetn sampled on posedge sb_clk).
- Reset values:
  - m_grant = 0, sb_size = 0, sb_master_id = 0.
  - sb_busy = 0, sb_last = 0, arb_err = 0.
  - rr_ptr = 0, beats_left = 0, state = IDLE.
- Reset mid-transaction: everything returns to the reset values on the next edge; no error pulse.
- Beat count from size:
  - 010→1, 011→2, 100→4, 101→8, 110→16, 111→32.
  - 000 and 001 → 1.
  - beats_left is 6 bits.
- States: IDLE, GRANT, CHECK, DATA, DONE, ERR. All outputs are registered.
- IDLE:
  - Samples m_req only in this state.
  - Winner = first requester found scanning from rr_ptr upward, wrapping modulo NUM_MASTERS.
  - If any request: next edge sets m_grant[winner], sb_master_id, sb_size, beats_left; goes to GRANT.
  - If no request: stays in IDLE.
- GRANT: one cycle, so the decoder registers address and size. → CHECK.
- CHECK: one cycle; decoder result is valid here.
  - add_notokay = 1 → ERR.
  - Otherwise → DATA.
- DATA:
  - Each edge with sb_ready = 1 decrements beats_left.
  - sb_ready = 1 with beats_left == 1 → DONE.
  - sb_ready = 0 holds the state and count.
- DONE:
  - m_grant cleared on entry.
  - rr_ptr ← (winner+1) mod NUM_MASTERS.
  - → IDLE next edge.
  - Minimum gap between successive grants is 1 IDLE cycle.
- ERR:
  - m_grant cleared on entry; arb_err = 1 for exactly this cycle.
  - rr_ptr advances as in DONE.
  - → IDLE.
- A master dropping m_req while granted is ignored; the transaction runs to DONE or ERR.
- add_notokay outside CHECK is ignored.
- sb_ready outside DATA is ignored.
- Single requester: re-granted after each IDLE cycle. No starvation: any continuously requesting master is granted within NUM_MASTERS transactions.

Optional Feature:
- Macro: SB_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit idle counter clears on entry to DATA and on every sb_ready.
  - It increments otherwise.
  - On reaching TIMEOUT_CYCLES in DATA → ERR (arb_err pulse, grant dropped, rr_ptr advances).
- Undefined: no counter is built, and DATA waits indefinitely for sb_ready.

Test Plan:
1. Reset then idle:
   - Stimulus: sb_resetn low 3 cycles, m_req = 000.
   - Response: all outputs 0, state stays IDLE, sb_busy = 0.
2. Single transfer:
   - Stimulus: m_req = 001, m_size[2:0] = 100, add_notokay = 0, sb_ready held 1.
   - Response: m_grant = 001 one edge after request, then GRANT/CHECK, then 4 DATA cycles. sb_last high on the 4th. Grant drops in DONE; rr_ptr = 1.
3. Round-robin:
   - Stimulus: m_req = 111 held, all sizes 010.
   - Response: grant order 001, 010, 100, 001. sb_master_id 0, 1, 2, 0.
4. Address error:
   - Stimulus: m_req = 010, add_notokay = 1 during CHECK.
   - Response: no DATA state, m_grant = 0 and arb_err = 1 for exactly one cycle, rr_ptr = 2.
5. Wait states and mid-burst reset:
   - Stimulus: size 011, sb_ready pattern 0, 1, 0, 1.
   - Response: DONE after the second ready.
   - Repeat with sb_resetn low during DATA: all outputs 0 next edge, arb_err stays 0.
6. Timeout (SB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 10):
   - Stimulus: sb_ready held 0 in DATA.
   - Response: ERR after 10 DATA cycles, one arb_err pulse.
   - Without the macro: remains in DATA for 100+ cycles.

Source files
------------

// File: rtl/sb_arbiter_if.sv
// SB arbiter bus bundle: requester request/size lines, decoder/slave status and arbiter results.
interface sb_arbiter_if #(
  parameter int NUM_MASTERS   = 3,
  parameter int SB_TRANS_SIZE = 3,
  parameter int ID_WIDTH      = 3
);
  logic [NUM_MASTERS-1:0]               m_req;
  logic [NUM_MASTERS*SB_TRANS_SIZE-1:0] m_size;
  logic                                 sb_ready;
  logic                                 add_notokay;
  logic [NUM_MASTERS-1:0]               m_grant;
  logic [SB_TRANS_SIZE-1:0]             sb_size;
  logic [ID_WIDTH-1:0]                  sb_master_id;
  logic                                 sb_busy;
  logic                                 sb_last;
  logic                                 arb_err;

  modport master (
    input  m_req, m_size, sb_ready, add_notokay,
    output m_grant, sb_size, sb_master_id, sb_busy, sb_last, arb_err
  );

  modport slave (
    output m_req, m_size, sb_ready, add_notokay,
    input  m_grant, sb_size, sb_master_id, sb_busy, sb_last, arb_err
  );
endinterface

// File: rtl/sb_arbiter.sv
// Round-robin SB bus arbiter and transaction sequencer (grant, address check, beat count).
// Optional DATA-phase stall timeout is built when SB_ARB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | bus free, m_req sampled, round-robin winner chosen
// GRANT | decoder registers address/size of the winner
// CHECK | decoder address result valid
// DATA  | beats counted against sb_ready
// DONE  | transfer complete, grant released
// ERR   | transfer aborted, grant released, arb_err pulse
module sb_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int SB_TRANS_SIZE  = 3,
  parameter int ID_WIDTH       = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic          sb_clk,
  input logic          sb_resetn,
  sb_arbiter_if.master bus
);

  typedef enum logic [2:0] {IDLE, GRANT, CHECK, DATA, DONE, ERR} state_t;

  localparam logic [ID_WIDTH:0]   NM      = (ID_WIDTH+1)'(NUM_MASTERS);
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_MASTERS - 1);

  state_t                   state, state_n;
  logic [NUM_MASTERS-1:0]   grant_q, grant_n;
  logic [SB_TRANS_SIZE-1:0] size_q, size_n;
  logic [ID_WIDTH-1:0]      id_q, id_n;
  logic [ID_WIDTH-1:0]      rr_ptr, rr_ptr_n;
  logic [5:0]               beats_left, beats_n;
  logic                     busy_q, busy_n;
  logic                     last_q, last_n;
  logic                     err_q, err_n;

  logic [NUM_MASTERS-1:0]   req_rot;
  logic [ID_WIDTH:0]        sum;
  logic [ID_WIDTH-1:0]      winner;
  logic [ID_WIDTH-1:0]      next_ptr;
  logic [SB_TRANS_SIZE-1:0] win_size;

`ifdef SB_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] idle_cnt, idle_cnt_n;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  function automatic logic [5:0] size_to_beats(input logic [SB_TRANS_SIZE-1:0] s);
    logic [5:0] b;
    b = 6'd1;
    case (s)
      SB_TRANS_SIZE'(3): b = 6'd2;
      SB_TRANS_SIZE'(4): b = 6'd4;
      SB_TRANS_SIZE'(5): b = 6'd8;
      SB_TRANS_SIZE'(6): b = 6'd16;
      SB_TRANS_SIZE'(7): b = 6'd32;
      default:           b = 6'd1;
    endcase
    return b;
  endfunction

  // Rotate requests so bit 0 is the master at rr_ptr; lowest set bit wins.
  assign req_rot  = NUM_MASTERS'({bus.m_req, bus.m_req} >> rr_ptr);
  assign next_ptr = (id_q == LAST_ID) ? '0 : id_q + ID_WIDTH'(1);

  always_comb begin
    winner   = '0;
    sum      = '0;
    win_size = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        sum = {1'b0, rr_ptr} + (ID_WIDTH+1)'(k);
        if (sum >= NM) sum = sum - NM;
        winner = sum[ID_WIDTH-1:0];
      end
    end
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (winner == ID_WIDTH'(j)) win_size = bus.m_size[j*SB_TRANS_SIZE +: SB_TRANS_SIZE];
    end
  end

  always_comb begin
    state_n  = state;
    grant_n  = grant_q;
    size_n   = size_q;
    id_n     = id_q;
    rr_ptr_n = rr_ptr;
    beats_n  = beats_left;
`ifdef SB_ARB_TIMEOUT_EN
    idle_cnt_n = idle_cnt;
`endif
    unique case (state)
      IDLE: begin
        if (|bus.m_req) begin
          state_n = GRANT;
          grant_n = NUM_MASTERS'(1) << winner;
          id_n    = winner;
          size_n  = win_size;
          beats_n = size_to_beats(win_size);
        end
      end
      GRANT: state_n = CHECK;
      CHECK: begin
        if (bus.add_notokay) begin
          state_n  = ERR;
          grant_n  = '0;
          rr_ptr_n = next_ptr;
        end else begin
          state_n = DATA;
`ifdef SB_ARB_TIMEOUT_EN
          idle_cnt_n = '0;
`endif
        end
      end
      DATA: begin
        if (bus.sb_ready) begin
          beats_n = beats_left - 6'd1;
`ifdef SB_ARB_TIMEOUT_EN
          idle_cnt_n = '0;
`endif
          if (beats_left == 6'd1) begin
            state_n  = DONE;
            grant_n  = '0;
            rr_ptr_n = next_ptr;
          end
        end
`ifdef SB_ARB_TIMEOUT_EN
        else if (idle_cnt == TMO_LAST) begin
          state_n  = ERR;
          grant_n  = '0;
          rr_ptr_n = next_ptr;
        end else begin
          idle_cnt_n = idle_cnt + 16'd1;
        end
`endif
      end
      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
    last_n = (state_n == DATA) && (beats_n == 6'd1);
    err_n  = (state_n == ERR);
  end

  always_ff @(posedge sb_clk) begin
    if (!sb_resetn) begin
      state      <= IDLE;
      grant_q    <= '0;
      size_q     <= '0;
      id_q       <= '0;
      rr_ptr     <= '0;
      beats_left <= '0;
      busy_q     <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      grant_q    <= grant_n;
      size_q     <= size_n;
      id_q       <= id_n;
      rr_ptr     <= rr_ptr_n;
      beats_left <= beats_n;
      busy_q     <= busy_n;
      last_q     <= last_n;
      err_q      <= err_n;
    end
  end

`ifdef SB_ARB_TIMEOUT_EN
  always_ff @(posedge sb_clk) begin
    if (!sb_resetn) idle_cnt <= '0;
    else            idle_cnt <= idle_cnt_n;
  end
`endif

  assign bus.m_grant      = grant_q;
  assign bus.sb_size      = size_q;
  assign bus.sb_master_id = id_q;
  assign bus.sb_busy      = busy_q;
  assign bus.sb_last      = last_q;
  assign bus.arb_err      = err_q;

endmodule

// File: tb/tb_sb_arbiter.sv
// Bench for sb_arbiter: transaction-level reference model checked every cycle plus directed literal checks.
module tb_sb_arbiter;
  localparam int N   = 3;
  localparam int SW  = 3;
  localparam int IW  = 3;
  localparam int TMO = 10;

  logic sb_clk = 1'b0;
  logic sb_resetn = 1'b0;
  always #5 sb_clk = ~sb_clk;

  sb_arbiter_if #(.NUM_MASTERS(N), .SB_TRANS_SIZE(SW), .ID_WIDTH(IW)) bus ();

  sb_arbiter #(.NUM_MASTERS(N), .SB_TRANS_SIZE(SW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TMO)) dut (
    .sb_clk   (sb_clk),
    .sb_resetn(sb_resetn),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the bus, how long since grant, beats still owed.
  typedef struct {
    int owner;   // -1 when nobody holds the bus
    int age;     // 1 = address cycle, 2 = check cycle, 3 = data phase
    int rem;
    int tail;    // 1 = completion cycle, 2 = abort cycle
    int ptr;
    int size;
    int id;
    int tmo;
  } model_t;

  model_t mdl;

  function automatic int beats_of(input int s);
    case (s)
      3: return 2;
      4: return 4;
      5: return 8;
      6: return 16;
      7: return 32;
      default: return 1;
    endcase
  endfunction

  function automatic model_t release_bus(input model_t m, input int how);
    model_t r = m;
    r.ptr   = (m.owner + 1) % N;
    r.owner = -1;
    r.age   = 0;
    r.tail  = how;
    return r;
  endfunction

  function automatic model_t step(input model_t m, input logic rstn, input logic [N-1:0] req,
                                 input logic [N*SW-1:0] sizes, input logic rdy, input logic nok);
    model_t r = m;
    if (!rstn) begin
      r.owner = -1; r.age = 0; r.rem = 0; r.tail = 0;
      r.ptr = 0; r.size = 0; r.id = 0; r.tmo = 0;
      return r;
    end
    if (m.tail != 0) begin
      r.tail = 0;
    end else if (m.owner < 0) begin
      for (int k = N - 1; k >= 0; k--) begin
        int idx = (m.ptr + k) % N;
        if (req[idx]) r.owner = idx;
      end
      if (r.owner >= 0) begin
        r.id   = r.owner;
        r.size = int'(sizes >> (SW * r.owner)) & 7;
        r.rem  = beats_of(r.size);
        r.age  = 1;
      end
    end else if (m.age == 1) begin
      r.age = 2;
    end else if (m.age == 2) begin
      if (nok) r = release_bus(m, 2);
      else begin r.age = 3; r.tmo = 0; end
    end else if (rdy) begin
      r.rem = m.rem - 1;
      r.tmo = 0;
      if (r.rem == 0) r = release_bus(r, 1);
    end else begin
      r.tmo = m.tmo + 1;
`ifdef SB_ARB_TIMEOUT_EN
      if (r.tmo == TMO) r = release_bus(r, 2);
`endif
    end
    return r;
  endfunction

  always @(posedge sb_clk)
    mdl <= step(mdl, sb_resetn, bus.m_req, bus.m_size, bus.sb_ready, bus.add_notokay);

  always @(negedge sb_clk) begin
    chk("grant",  32'(bus.m_grant),      (mdl.owner >= 0) ? 32'(1 << mdl.owner) : 32'd0);
    chk("size",   32'(bus.sb_size),      32'(mdl.size));
    chk("id",     32'(bus.sb_master_id), 32'(mdl.id));
    chk("busy",   32'(bus.sb_busy),      32'(mdl.owner >= 0 || mdl.tail != 0));
    chk("last",   32'(bus.sb_last),      32'(mdl.owner >= 0 && mdl.age == 3 && mdl.rem == 1));
    chk("arberr", 32'(bus.arb_err),      32'(mdl.tail == 2));
  end

  // Follows one transaction from request to grant release; ready pattern index 1 = first granted cycle.
  task automatic track(input int max, input logic [63:0] pat, input bit drop,
                       output int hi, output int ls, output int es,
                       output logic [2:0] g0, output logic [2:0] id0, output int first_at);
    bit seen = 1'b0;
    bit done = 1'b0;
    int p;
    hi = 0; ls = 0; es = 0; g0 = '0; id0 = '0; first_at = -1;
    for (int i = 1; i <= max && !done; i++) begin
      @(negedge sb_clk);
      if (bus.m_grant != '0) begin
        if (!seen) begin
          g0 = bus.m_grant; id0 = bus.sb_master_id; first_at = i;
          if (drop) bus.m_req = '0;
        end
        seen = 1'b1;
        hi++;
      end
      if (bus.sb_last) ls++;
      if (bus.arb_err) es++;
      if (seen && bus.m_grant == '0) done = 1'b1;
      p = seen ? (i - first_at + 1) : 0;
      if (p > 63) p = 63;
      bus.sb_ready = pat[p[5:0]];
    end
    chk("track_done", 32'(done), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, ls, es, fa;
    logic [2:0] g0, id0;
    logic [2:0] rr_g  [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [2:0] rr_id [4] = '{3'd0, 3'd1, 3'd2, 3'd0};

    bus.m_req = '0; bus.m_size = '0; bus.sb_ready = 1'b0; bus.add_notokay = 1'b0;

    // 1: reset then idle
    repeat (3) @(negedge sb_clk);
    chk("t1_rst_grant", 32'(bus.m_grant), 32'd0);
    chk("t1_rst_busy",  32'(bus.sb_busy), 32'd0);
    sb_resetn = 1'b1;
    repeat (3) @(negedge sb_clk);
    chk("t1_idle_busy", 32'(bus.sb_busy), 32'd0);
    chk("t1_idle_err",  32'(bus.arb_err), 32'd0);

    // 2: single 4-beat transfer from master 0
    bus.m_size = 9'b000_000_100; bus.m_req = 3'b001; bus.sb_ready = 1'b1;
    track(100, '1, 1'b1, hi, ls, es, g0, id0, fa);
    chk("t2_grant",    32'(g0), 32'b001);
    chk("t2_latency",  32'(fa), 32'd1);
    chk("t2_held",     32'(hi), 32'd6);
    chk("t2_last_cnt", 32'(ls), 32'd1);
    chk("t2_err_cnt",  32'(es), 32'd0);

    // 3: round-robin from a fresh pointer, all masters requesting
    sb_resetn = 1'b0;
    @(negedge sb_clk);
    sb_resetn = 1'b1;
    bus.m_size = 9'b010_010_010; bus.m_req = 3'b111;
    for (int t = 0; t < 4; t++) begin
      track(100, '1, t == 3, hi, ls, es, g0, id0, fa);
      chk("t3_grant", 32'(g0),  32'(rr_g[t]));
      chk("t3_id",    32'(id0), 32'(rr_id[t]));
      chk("t3_held",  32'(hi),  32'd3);
      chk("t3_gap",   32'(fa),  (t == 0) ? 32'd1 : 32'd2);
    end

    // 4: address error on master 1, then pointer must have moved to master 2
    @(negedge sb_clk);
    bus.m_req = 3'b010; bus.add_notokay = 1'b1;
    track(50, '1, 1'b1, hi, ls, es, g0, id0, fa);
    chk("t4_grant",    32'(g0), 32'b010);
    chk("t4_held",     32'(hi), 32'd2);
    chk("t4_err_cnt",  32'(es), 32'd1);
    chk("t4_last_cnt", 32'(ls), 32'd0);
    bus.add_notokay = 1'b0; bus.m_req = 3'b111;
    track(50, '1, 1'b1, hi, ls, es, g0, id0, fa);
    chk("t4_next_grant", 32'(g0),  32'b100);
    chk("t4_next_id",    32'(id0), 32'd2);

    // 5: two beats with wait states, ready 0,1,0,1 across DATA
    @(negedge sb_clk);
    bus.m_size = 9'b010_010_011; bus.m_req = 3'b001; bus.sb_ready = 1'b0;
    track(50, 64'h50, 1'b1, hi, ls, es, g0, id0, fa);
    chk("t5_held",     32'(hi), 32'd6);
    chk("t5_last_cnt", 32'(ls), 32'd2);
    chk("t5_err_cnt",  32'(es), 32'd0);

    // 5b: reset during DATA
    @(negedge sb_clk);
    bus.m_req = 3'b001; bus.sb_ready = 1'b0;
    repeat (3) @(negedge sb_clk);
    chk("t5b_in_data", 32'(bus.m_grant), 32'b001);
    sb_resetn = 1'b0;
    @(negedge sb_clk);
    chk("t5b_grant", 32'(bus.m_grant), 32'd0);
    chk("t5b_busy",  32'(bus.sb_busy), 32'd0);
    chk("t5b_last",  32'(bus.sb_last), 32'd0);
    chk("t5b_err",   32'(bus.arb_err), 32'd0);
    bus.m_req = '0;
    sb_resetn = 1'b1;
    repeat (2) @(negedge sb_clk);
    chk("t5b_err_after", 32'(bus.arb_err), 32'd0);

    // 6: slave never ready
    bus.m_size = 9'b010_010_000; bus.m_req = 3'b001; bus.sb_ready = 1'b0;
`ifdef SB_ARB_TIMEOUT_EN
    track(60, 64'h0, 1'b1, hi, ls, es, g0, id0, fa);
    chk("t6_held",    32'(hi), 32'd12);
    chk("t6_err_cnt", 32'(es), 32'd1);
`else
    repeat (3) @(negedge sb_clk);
    bus.m_req = '0;
    repeat (120) @(negedge sb_clk);
    chk("t6_still_grant", 32'(bus.m_grant), 32'b001);
    chk("t6_still_busy",  32'(bus.sb_busy), 32'd1);
    chk("t6_still_last",  32'(bus.sb_last), 32'd1);
    bus.sb_ready = 1'b1;
    @(negedge sb_clk);
    chk("t6_done_grant", 32'(bus.m_grant), 32'd0);
    chk("t6_done_busy",  32'(bus.sb_busy), 32'd1);
    bus.sb_ready = 1'b0;
`endif

    // 7: largest size, 32 beats from master 1
    @(negedge sb_clk);
    bus.m_size = 9'b000_111_000; bus.m_req = 3'b010; bus.sb_ready = 1'b1;
    track(100, '1, 1'b1, hi, ls, es, g0, id0, fa);
    chk("t7_grant",    32'(g0),  32'b010);
    chk("t7_id",       32'(id0), 32'd1);
    chk("t7_held",     32'(hi),  32'd34);
    chk("t7_last_cnt", 32'(ls),  32'd1);

    repeat (3) @(negedge sb_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
